// File: rtl/adder_result_accumulator.sv
// Sums COUNT adder results ({cout,sum}) into an ACC_WIDTH total with sticky wrap flag and early flush.
// Total appears one cycle after the last accept and is held until out_ready takes it.
module adder_result_accumulator #(
  parameter int WIDTH     = 12,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_cout,
  input  logic                 flush,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic [7:0]           sample_cnt
);

  typedef enum logic {ACCUM, DONE} state_t;
  state_t state;

  logic [ACC_WIDTH:0] sum_next;
  logic               accept;
  logic               last;

  // One extra bit on the add exposes the carry out of the accumulator MSB.
  assign sum_next = {1'b0, acc_out} + (ACC_WIDTH+1)'({in_cout, in_sum});
  assign accept   = in_valid && in_ready;
  assign last     = (sample_cnt == 8'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc_out    <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_out    <= sum_next[ACC_WIDTH-1:0];
            overflow   <= overflow | sum_next[ACC_WIDTH];
            sample_cnt <= sample_cnt + 8'd1;
            if (last || flush) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end else if (flush && sample_cnt != 8'd0) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= ACCUM;
            acc_out    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
Downstream consumer of the 12-bit uniform adder. It takes each {cout, sum} result through a valid/ready handshake and accumulates COUNT results into a wider register. It presents the batch total on an output valid/ready handshake, with a sticky overflow flag and an early-flush option. It is the stage that turns single-shot adder results into running totals for the rest of the datapath.

Parameters:
WIDTH, 12, adder sum width; sample value is {in_cout, in_sum}, i.e. WIDTH+1 bits, zero-extended.
COUNT, 4, samples per batch; legal range 1..255.
ACC_WIDTH, 16, accumulator width; must be >= WIDTH+1.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream sample present.
in_ready  output  1  block can accept a sample this cycle.
in_sum  input  WIDTH  adder sum output.
in_cout  input  1  adder carry-out.
flush  input  1  end the current batch early; sampled only in ACCUM.
acc_out  output  ACC_WIDTH  batch total; stable while out_valid=1.
out_valid  output  1  batch total available.
out_ready  input  1  downstream accepts the total.
overflow  output  1  sticky within a batch: the true total exceeded 2^ACC_WIDTH-1.
sample_cnt  output  8  samples accepted in the current batch.

Behaviour:
- Reset (synchronous, active-high): state=ACCUM, acc_out=0, sample_cnt=0, overflow=0, out_valid=0, in_ready=1. Reset overrides all other inputs and aborts any batch, including one held in DONE.
- States: ACCUM and DONE only.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: acc_out <= (acc_out + {in_cout,in_sum}) mod 2^ACC_WIDTH; overflow <= overflow | carry out of bit ACC_WIDTH-1; sample_cnt <= sample_cnt+1.
  - If this accept makes sample_cnt reach COUNT, go to DONE next cycle.
  - out_valid rises the cycle after the last accept (latency 1). The register update and the state change happen on the same edge.
- flush in ACCUM:
  - flush=1 with sample_cnt>0 and no accept: go to DONE with the current total.
  - flush=1 with an accept in the same cycle: include the sample, then go to DONE.
  - flush=1 with sample_cnt=0 and no accept: ignored.
- DONE:
  - in_ready=0, out_valid=1; acc_out, overflow and sample_cnt are held stable.
  - in_valid is ignored and nothing is accepted.
  - flush is ignored.
  - On out_valid & out_ready: acc_out, sample_cnt and overflow clear to 0, state goes to ACCUM next cycle, and in_ready is 1 in that next cycle. There is no same-cycle pass-through.
- Handshake rules: in_ready is a function of state only, with no combinational path from in_valid or out_ready. out_valid, once high, stays high until the transfer completes.
- Wrap-around: the accumulator wraps modulo 2^ACC_WIDTH; overflow records that it wrapped. sample_cnt never exceeds COUNT.
- COUNT=1: every accepted sample produces an output. The throughput limit is 1 sample per 2 cycles when out_ready is held high.

Test Plan:
- Reset mid-batch: accept 0x005, then assert rst for 1 cycle -> acc_out=0, sample_cnt=0, out_valid=0, in_ready=1 the next cycle.
- Basic batch, COUNT=4, out_ready=1: samples {cout,sum} = 0x0002, 0x0005, 0x1002 (from 0x800+0x802), 0x0000 -> out_valid=1 one cycle after the 4th accept, acc_out=0x1009, overflow=0, sample_cnt=4; in_ready=1 again the cycle after the transfer.
- Backpressure: complete a batch with out_ready=0 for 5 cycles while in_valid=1 with value 0x0123 -> acc_out stays stable, in_ready=0, no sample is absorbed; raise out_ready -> one transfer, next batch starts from 0.
- Overflow with ACC_WIDTH=14, COUNT=4: four samples of 0x1FFF -> acc_out=0x3FFC, overflow=1; overflow clears after the transfer.
- Flush: accept 0x0010, 0x0020, then flush=1 without in_valid -> DONE with acc_out=0x0030, sample_cnt=2. flush in the same cycle as accepting 0x0001 on an empty batch -> acc_out=0x0001, sample_cnt=1. flush with sample_cnt=0 and no accept -> no state change.
- Gaps in in_valid: 4 samples of 0x0001 with idle cycles between each -> acc_out=0x0004. Only accepted cycles are counted.
